// File: rtl/sm4_mode_ctrl_pkg.sv
// Shared constants for the SM4 block-mode controller: block width and FSM state encodings.
package sm4_mode_ctrl_pkg;

    localparam int sm4_group_size_lp = 128;

    typedef logic [2:0] mode_state_t;

    localparam mode_state_t eIdle  = 3'd0;
    localparam mode_state_t eReady = 3'd1;
    localparam mode_state_t eIssue = 3'd2;
    localparam mode_state_t eWait  = 3'd3;
    localparam mode_state_t eOut   = 3'd4;

endpackage

// File: rtl/sm4_mode_ctrl.sv
// SM4 block-mode controller: feeds one block at a time to an sm4_encryptor engine and chains results.
// Define SM4_MODE_CBC_EN for CBC chaining; leave it undefined for plain ECB (cfg_iv_i unused).
module sm4_mode_ctrl
    import sm4_mode_ctrl_pkg::*;
#(
    parameter int group_size_p = sm4_group_size_lp,
    parameter int cnt_width_p  = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    cfg_v_i,
    input  logic [group_size_p-1:0] cfg_key_i,
    input  logic [group_size_p-1:0] cfg_iv_i,
    input  logic                    cfg_decode_i,
    input  logic                    cfg_flush_i,
    input  logic [group_size_p-1:0] data_i,
    input  logic                    last_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [group_size_p-1:0] data_o,
    output logic                    last_o,
    output logic                    v_o,
    input  logic                    yumi_i,
    output logic [cnt_width_p-1:0]  blk_cnt_o,
    output logic [group_size_p-1:0] eng_content_o,
    output logic [group_size_p-1:0] eng_key_o,
    output logic                    eng_decode_o,
    output logic                    eng_v_o,
    input  logic                    eng_ready_i,
    input  logic [group_size_p-1:0] eng_crypt_i,
    input  logic                    eng_v_i,
    output logic                    eng_yumi_o,
    output logic                    eng_invalid_o
);

    mode_state_t             state_q, state_d;
    logic [group_size_p-1:0] key_q, key_d;
    logic [group_size_p-1:0] blk_q, blk_d;
    logic [group_size_p-1:0] res_q, res_d;
    logic                    decode_q, decode_d;
    logic                    last_q, last_d;
    logic [cnt_width_p-1:0]  cnt_q, cnt_d;

    logic                    cfg_take;
    logic                    res_take;
    logic [group_size_p-1:0] content;
    logic [group_size_p-1:0] result;

    assign cfg_take = (state_q == eIdle) && cfg_v_i;
    assign res_take = (state_q == eWait) && eng_v_i;

`ifdef SM4_MODE_CBC_EN
    logic [group_size_p-1:0] chain_q, chain_d;

    // Decrypt chains on the incoming ciphertext, which is still held in blk_q when the result lands.
    always_comb begin
        chain_d = chain_q;
        if (cfg_take) begin
            chain_d = cfg_iv_i;
        end else if (res_take) begin
            chain_d = decode_q ? blk_q : eng_crypt_i;
        end
        content = decode_q ? blk_q : (blk_q ^ chain_q);
        result  = decode_q ? (eng_crypt_i ^ chain_q) : eng_crypt_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end
`else
    logic unused_iv;

    assign unused_iv = ^cfg_iv_i;
    assign content   = blk_q;
    assign result    = eng_crypt_i;
`endif

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        decode_d = decode_q;
        blk_d    = blk_q;
        last_d   = last_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        case (state_q)
            eIdle: begin
                if (cfg_v_i) begin
                    key_d    = cfg_key_i;
                    decode_d = cfg_decode_i;
                    cnt_d    = '0;
                    state_d  = eReady;
                end
            end
            eReady: begin
                if (v_i) begin
                    blk_d   = data_i;
                    last_d  = last_i;
                    state_d = eIssue;
                end
            end
            eIssue: begin
                if (eng_ready_i) begin
                    state_d = eWait;
                end
            end
            eWait: begin
                if (eng_v_i) begin
                    res_d   = result;
                    state_d = eOut;
                end
            end
            eOut: begin
                if (yumi_i) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + cnt_width_p'(1);
                    end
                    state_d = last_q ? eIdle : eReady;
                end
            end
            default: state_d = eIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= eIdle;
            key_q    <= '0;
            decode_q <= 1'b0;
            blk_q    <= '0;
            last_q   <= 1'b0;
            res_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            decode_q <= decode_d;
            blk_q    <= blk_d;
            last_q   <= last_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ready_o       = (state_q == eReady);
    assign v_o           = (state_q == eOut);
    assign data_o        = res_q;
    assign last_o        = (state_q == eOut) && last_q;
    assign blk_cnt_o     = cnt_q;
    assign eng_content_o = content;
    assign eng_key_o     = key_q;
    assign eng_decode_o  = decode_q;
    assign eng_v_o       = (state_q == eIssue);
    assign eng_yumi_o    = (state_q == eWait) && eng_v_i;
    assign eng_invalid_o = cfg_take && cfg_flush_i;

endmodule
